// File: rtl/byte_frame_arbiter_pkg.sv
// Shared types and constants for the two-requester byte frame arbiter.
package byte_frame_arbiter_pkg;

    localparam int NBYTES = 7;
    localparam int BYTE_W = 8;
    localparam int BUF_W  = NBYTES * BYTE_W;
    localparam int IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/byte_frame_arbiter_buf.sv
// 56-bit byte shift register: new bytes enter at [7:0], oldest byte sits at [55:48].
module byte_shift_buf
    import byte_frame_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_en,
    input  logic [BYTE_W-1:0] din,
    input  logic [IDX_W-1:0]  sel,
    output logic [BYTE_W-1:0] dout
);

    logic [BUF_W-1:0] sbuf;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sbuf <= '0;
        end else if (load_en) begin
            sbuf <= {sbuf[BUF_W-BYTE_W-1:0], din};
        end
    end

    // Selects beyond the frame read as zero rather than aliasing.
    always_comb begin
        dout = '0;
        if (sel < IDX_W'(NBYTES)) begin
            dout = sbuf[sel*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/byte_frame_arbiter.sv
// Grants a shared 7-byte frame buffer to one of two byte requesters, loads a frame, then drains it.
module byte_frame_arbiter
    import byte_frame_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              owner,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rd;
    logic             prio;

    logic              in_load;
    logic              in_drain;
    logic              owner_valid;
    logic [BYTE_W-1:0] owner_data;
    logic              accept;
    logic              buf_clr;

    assign in_load     = (state == LOAD);
    assign in_drain    = (state == DRAIN);
    assign owner_valid = owner ? req1_valid : req0_valid;
    assign owner_data  = owner ? req1_data  : req0_data;
    assign accept      = in_load && !flush && owner_valid;
    assign buf_clr     = flush && (state != IDLE);

    // Readies and out_valid come from registered state (plus the flush kill), never from valid/ready inputs.
    assign req0_ready = in_load && !owner && !flush;
    assign req1_ready = in_load &&  owner && !flush;
    assign out_valid  = in_drain;
    assign out_last   = in_drain && (rd == '0);
    assign busy       = (state != IDLE);

    byte_shift_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .load_en (accept),
        .din     (owner_data),
        .sel     (rd),
        .dout    (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rd        <= '0;
            prio      <= 1'b0;
            owner     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && (req0_valid || req1_valid)) begin
                        owner <= (req0_valid && req1_valid) ? prio : req1_valid;
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (flush) begin
                        state <= IDLE;
                        idx   <= '0;
                        rd    <= '0;
                    end else if (accept) begin
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                            idx   <= '0;
                            rd    <= LAST_IDX;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state <= IDLE;
                        idx   <= '0;
                        rd    <= '0;
                    end else if (out_ready) begin
                        if (rd == '0) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 8'd1;
                            prio      <= ~owner;
                        end else begin
                            rd <= rd - IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_frame_arbiter.sv
// Directed bench for byte_frame_arbiter with a queue-based frame model checked every cycle.
module tb_byte_frame_arbiter;

    localparam int NB       = 7;
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       owner;
    logic       busy;
    logic [7:0] frame_cnt;

    byte_frame_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .owner      (owner),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: a byte queue filled in arrival order and emptied from the front.
    int         m_phase = PH_IDLE;
    bit         m_owner = 1'b0;
    bit         m_prio = 1'b0;
    logic [7:0] m_fcnt = 8'h00;
    logic [7:0] m_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = PH_IDLE;
            m_owner = 1'b0;
            m_prio  = 1'b0;
            m_fcnt  = 8'h00;
            m_q.delete();
        end else begin
            case (m_phase)
                PH_IDLE: if (!flush && (req0_valid || req1_valid)) begin
                    m_owner = (req0_valid && req1_valid) ? m_prio : req1_valid;
                    m_phase = PH_LOAD;
                    m_q.delete();
                end
                PH_LOAD: if (flush) begin
                    m_phase = PH_IDLE;
                    m_q.delete();
                end else if (m_owner ? req1_valid : req0_valid) begin
                    m_q.push_back(m_owner ? req1_data : req0_data);
                    if (m_q.size() == NB) m_phase = PH_DRAIN;
                end
                PH_DRAIN: if (flush) begin
                    m_phase = PH_IDLE;
                    m_q.delete();
                end else if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_phase = PH_IDLE;
                        m_fcnt  = m_fcnt + 8'd1;
                        m_prio  = !m_owner;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    logic [7:0] got[$];
    logic [7:0] expq[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req0_ready", req0_ready, (m_phase == PH_LOAD) && !m_owner && !flush);
            chk("req1_ready", req1_ready, (m_phase == PH_LOAD) && m_owner && !flush);
            chk("out_valid", out_valid, m_phase == PH_DRAIN);
            chk("out_last", out_last, (m_phase == PH_DRAIN) && (m_q.size() == 1));
            chk("busy", busy, m_phase != PH_IDLE);
            chk("frame_cnt", frame_cnt, m_fcnt);
            if (m_phase == PH_DRAIN) chk("out_data", out_data, m_q[0]);
            if (m_phase != PH_IDLE) chk("owner", owner, m_owner);
            if (rst_n && out_valid && out_ready && !flush) got.push_back(out_data);
        end
    end

    task automatic push_byte(input bit who, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        if (who) begin
            req1_valid = 1'b1;
            req1_data  = d;
        end else begin
            req0_valid = 1'b1;
            req0_data  = d;
        end
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = who ? req1_ready : req0_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout who=%0d byte=%0h actual=not_accepted required=accepted", who, d);
        end
    endtask

    task automatic send_frame(input bit who, input logic [7:0] base, input logic [7:0] inc);
        logic [7:0] d;
        d = base;
        for (int i = 0; i < NB; i++) begin
            push_byte(who, d);
            d = d + inc;
        end
        if (who) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input logic [7:0] base, input logic [7:0] inc);
        logic [7:0] d;
        d = base;
        for (int i = 0; i < NB; i++) begin
            expq.push_back(d);
            d = d + inc;
        end
    endtask

    task automatic chk_got(input string name);
        chk({name, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) chk(name, got[i], expq[i]);
        got.delete();
        expq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        expq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_ready0", req0_ready, 0);
        rst_n = 1'b1;

        // Single requester, grant latency, in-order drain.
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        @(negedge clk);
        chk("grant_pending", req0_ready, 0);
        @(posedge clk);
        #1;
        chk("grant_latency", req0_ready, 1);
        send_frame(1'b0, 8'h11, 8'h11);
        wait_idle();
        add_exp(8'h11, 8'h11);
        chk_got("single_bytes");
        chk("single_frame_cnt", frame_cnt, 1);

        // prio now points at req1: with both valid, req1 goes first.
        fork
            send_frame(1'b0, 8'hC0, 8'h01);
            send_frame(1'b1, 8'hD0, 8'h01);
        join
        wait_idle();
        add_exp(8'hD0, 8'h01);
        add_exp(8'hC0, 8'h01);
        chk_got("prio_order");

        // Contention from reset: req0 first, then req1.
        do_reset();
        fork
            send_frame(1'b0, 8'hA0, 8'h01);
            send_frame(1'b1, 8'hB0, 8'h01);
        join
        wait_idle();
        add_exp(8'hA0, 8'h01);
        add_exp(8'hB0, 8'h01);
        chk_got("contention");
        chk("contention_cnt", frame_cnt, 2);

        // Backpressure pattern 1,0,0,1 on out_ready.
        fork
            send_frame(1'b0, 8'h31, 8'h01);
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        add_exp(8'h31, 8'h01);
        chk_got("backpressure");

        // Owner valid gap of 3 cycles while the other requester waits.
        for (int i = 0; i < 4; i++) push_byte(1'b0, 8'h41 + 8'(i));
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h99;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req1_valid = 1'b0;
        for (int i = 4; i < NB; i++) push_byte(1'b0, 8'h41 + 8'(i));
        req0_valid = 1'b0;
        wait_idle();
        add_exp(8'h41, 8'h01);
        chk_got("valid_gap");
        chk("gap_frame_cnt", frame_cnt, 4);

        // Flush after 4 bytes, then flush in IDLE blocks a grant.
        for (int i = 0; i < 4; i++) push_byte(1'b0, 8'h51 + 8'(i));
        req0_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", busy, 0);
        chk("flush_cnt", frame_cnt, 4);
        flush = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_blocks_grant", busy, 0);
        flush = 1'b0;
        req1_valid = 1'b0;
        send_frame(1'b0, 8'h61, 8'h01);
        wait_idle();
        add_exp(8'h61, 8'h01);
        chk_got("post_flush");

        // Reset mid-DRAIN.
        out_ready = 1'b0;
        send_frame(1'b1, 8'h71, 8'h01);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rd_out_valid", out_valid, 0);
        chk("rd_out_data", out_data, 0);
        chk("rd_out_last", out_last, 0);
        chk("rd_busy", busy, 0);
        chk("rd_owner", owner, 0);
        chk("rd_frame_cnt", frame_cnt, 0);
        chk("rd_ready1", req1_ready, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        got.delete();

        // frame_cnt wrap after 256 frames.
        for (int f = 0; f < 256; f++) begin
            send_frame(1'b0, 8'(f), 8'h01);
            wait_idle();
            if (f == 254) chk("cnt_255", frame_cnt, 8'hFF);
        end
        chk("cnt_wrap", frame_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
